// File: rtl/ped_request_ctrl.sv
// Pedestrian crossing front end: debounces the crosswalk button, requests the
// pedestrian phase, and times walk, flashing clearance and cooldown.
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FLASH_SECS      = 3,
  parameter int unsigned COOLDOWN_SECS   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       button_i,
  input  logic       phase_grant_i,
  input  logic [6:0] load_time_i,
  output logic       ped_request_o,
  output logic [7:0] walk_light_o,
  output logic       ped_done_o,
  output logic       pending_o
);

  localparam int unsigned     DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [6:0]      FLASH_LOAD = 7'(FLASH_SECS);
  localparam logic [6:0]      COOL_LOAD  = 7'(COOLDOWN_SECS);
  localparam logic [7:0]      LIGHT_WALK = 8'hFF;
  localparam logic [7:0]      LIGHT_STOP = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WALK,
    S_FLASH,
    S_CLEAR
  } state_t;

  state_t          state_q;
  logic [6:0]      cnt_q;
  logic            ped_request_q;
  logic [7:0]      walk_light_q;
  logic            ped_done_q;

  logic            btn_s1_q;
  logic            btn_s2_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            press;
  logic            pending_q;
  logic            pending_d;
  logic            grant_accept;
  logic            cnt_last;

  // Counter saturates at DB_MAX so a held button registers exactly once.
  always_comb begin
    db_cnt_d = db_cnt_q;
    press    = 1'b0;
    if (!btn_s2_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_MAX) begin
      db_cnt_d = db_cnt_q + 1'b1;
      press    = (db_cnt_q == DB_MAX - 1'b1);
    end
  end

  assign grant_accept = (state_q == S_REQUEST) && phase_grant_i;
  assign pending_d    = press | (pending_q & ~grant_accept);
  assign cnt_last     = (cnt_q == 7'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      db_cnt_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      btn_s1_q  <= button_i;
      btn_s2_q  <= btn_s1_q;
      db_cnt_q  <= db_cnt_d;
      pending_q <= pending_d;
    end
  end

  // Ticks arriving in the grant cycle are deliberately not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ped_request_q <= 1'b0;
      walk_light_q  <= LIGHT_STOP;
      ped_done_q    <= 1'b0;
    end else begin
      ped_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            state_q       <= S_REQUEST;
            ped_request_q <= 1'b1;
          end
        end
        S_REQUEST: begin
          if (phase_grant_i) begin
            state_q       <= S_WALK;
            ped_request_q <= 1'b0;
            walk_light_q  <= LIGHT_WALK;
            cnt_q         <= (load_time_i == 7'd0) ? 7'd1 : load_time_i;
          end
        end
        S_WALK: begin
          if (!phase_grant_i || (tick_i && cnt_last)) begin
            state_q      <= S_FLASH;
            cnt_q        <= FLASH_LOAD;
            walk_light_q <= LIGHT_STOP;
          end else if (tick_i) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FLASH: begin
          if (tick_i) begin
            if (cnt_last) begin
              state_q      <= S_CLEAR;
              cnt_q        <= COOL_LOAD;
              walk_light_q <= LIGHT_STOP;
              ped_done_q   <= 1'b1;
            end else begin
              cnt_q        <= cnt_q - 1'b1;
              walk_light_q <= ~walk_light_q;
            end
          end
        end
        S_CLEAR: begin
          if (tick_i) begin
            if (cnt_last) begin
              cnt_q         <= '0;
              state_q       <= pending_q ? S_REQUEST : S_IDLE;
              ped_request_q <= pending_q;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_q       <= S_IDLE;
          cnt_q         <= '0;
          ped_request_q <= 1'b0;
          walk_light_q  <= LIGHT_STOP;
        end
      endcase
    end
  end

  assign ped_request_o = ped_request_q;
  assign walk_light_o  = walk_light_q;
  assign ped_done_o    = ped_done_q;
  assign pending_o     = pending_q;

endmodule
